// File: rtl/random_item_placer.sv
// random_item_placer: places one item per request on a GRID_W x GRID_H board.
// A free-running 16-bit LFSR is scaled into board coordinates; each candidate
// is checked against the game state through a one-cycle occupancy handshake.
// Optional raster-scan fallback after MAX_TRIES random hits is enabled by
// defining RANDOM_ITEM_SCAN_FALLBACK_EN.
`timescale 1ns/1ps

module random_item_placer #(
  parameter int unsigned GRID_W    = 32,
  parameter int unsigned GRID_H    = 24,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 8,
  localparam int unsigned XW = $clog2(GRID_W),
  localparam int unsigned YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          busy,
  output logic          occ_valid,
  output logic [XW-1:0] occ_x,
  output logic [YW-1:0] occ_y,
  input  logic          occ_hit,
  output logic [XW-1:0] item_x,
  output logic [YW-1:0] item_y,
  output logic          item_valid,
  output logic          fail
);

  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int unsigned   TW       = 8;
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
  localparam int unsigned   CELLS     = GRID_W * GRID_H;
  localparam int unsigned   SW        = $clog2(CELLS);
  localparam logic [SW-1:0] SCAN_LAST = SW'(CELLS - 1);
  localparam logic [XW-1:0] X_LAST    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST    = YW'(GRID_H - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    DRAW,
    QUERY,
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
    CHECK,
    SCAN_Q,
    SCAN_C
`else
    CHECK
`endif
  } state_t;

  state_t        state, state_d;
  logic [15:0]   lfsr;
  logic [TW-1:0] tries, tries_d;
  logic [XW-1:0] cand_x, cand_x_d;
  logic [YW-1:0] cand_y, cand_y_d;
  logic          busy_d, occ_valid_d, item_valid_d, fail_d;
  logic [XW-1:0] occ_x_d, item_x_d;
  logic [YW-1:0] occ_y_d, item_y_d;
  logic [15:0]   prod_x_c, prod_y_c;
  logic [XW-1:0] rnd_x_c;
  logic [YW-1:0] rnd_y_c;
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
  logic [SW-1:0] scan_cnt, scan_cnt_d;
  logic [XW-1:0] next_x_c;
  logic [YW-1:0] next_y_c;
`endif

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk) begin
    if (rst) lfsr <= SEED_EFF;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Multiply-scale the LFSR bytes so the candidate is always on the board
  always_comb begin
    prod_x_c = 16'(lfsr[15:8]) * 16'(GRID_W);
    prod_y_c = 16'(lfsr[7:0]) * 16'(GRID_H);
    rnd_x_c  = XW'(prod_x_c >> 8);
    rnd_y_c  = YW'(prod_y_c >> 8);
  end

`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
  // Raster successor of the current candidate, wrapping at both board edges
  always_comb begin
    next_x_c = cand_x + XW'(1);
    next_y_c = cand_y;
    if (cand_x == X_LAST) begin
      next_x_c = '0;
      next_y_c = (cand_y == Y_LAST) ? '0 : cand_y + YW'(1);
    end
  end
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tries      <= '0;
      cand_x     <= '0;
      cand_y     <= '0;
      busy       <= 1'b0;
      occ_valid  <= 1'b0;
      occ_x      <= '0;
      occ_y      <= '0;
      item_x     <= '0;
      item_y     <= '0;
      item_valid <= 1'b0;
      fail       <= 1'b0;
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
      scan_cnt   <= '0;
`endif
    end else begin
      state      <= state_d;
      tries      <= tries_d;
      cand_x     <= cand_x_d;
      cand_y     <= cand_y_d;
      busy       <= busy_d;
      occ_valid  <= occ_valid_d;
      occ_x      <= occ_x_d;
      occ_y      <= occ_y_d;
      item_x     <= item_x_d;
      item_y     <= item_y_d;
      item_valid <= item_valid_d;
      fail       <= fail_d;
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
      scan_cnt   <= scan_cnt_d;
`endif
    end
  end

  // Next state and next register values; strobes/pulses default low
  always_comb begin
    state_d      = state;
    tries_d      = tries;
    cand_x_d     = cand_x;
    cand_y_d     = cand_y;
    busy_d       = busy;
    occ_valid_d  = 1'b0;
    occ_x_d      = occ_x;
    occ_y_d      = occ_y;
    item_x_d     = item_x;
    item_y_d     = item_y;
    item_valid_d = 1'b0;
    fail_d       = 1'b0;
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
    scan_cnt_d   = scan_cnt;
`endif
    case (state)
      IDLE: begin
        if (req) begin
          state_d = DRAW;
          tries_d = '0;
          busy_d  = 1'b1;
        end
      end
      DRAW: begin
        cand_x_d    = rnd_x_c;
        cand_y_d    = rnd_y_c;
        occ_valid_d = 1'b1;
        occ_x_d     = rnd_x_c;
        occ_y_d     = rnd_y_c;
        state_d     = QUERY;
      end
      QUERY: state_d = CHECK;
      CHECK: begin
        if (!occ_hit) begin
          item_x_d     = cand_x;
          item_y_d     = cand_y;
          item_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (tries < TRY_LAST) begin
          tries_d = tries + TW'(1);
          state_d = DRAW;
        end else begin
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
          cand_x_d    = next_x_c;
          cand_y_d    = next_y_c;
          occ_valid_d = 1'b1;
          occ_x_d     = next_x_c;
          occ_y_d     = next_y_c;
          scan_cnt_d  = '0;
          state_d     = SCAN_Q;
`else
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`endif
        end
      end
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
      SCAN_Q: state_d = SCAN_C;
      SCAN_C: begin
        if (!occ_hit) begin
          item_x_d     = cand_x;
          item_y_d     = cand_y;
          item_valid_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (scan_cnt == SCAN_LAST) begin
          fail_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          scan_cnt_d  = scan_cnt + SW'(1);
          cand_x_d    = next_x_c;
          cand_y_d    = next_y_c;
          occ_valid_d = 1'b1;
          occ_x_d     = next_x_c;
          occ_y_d     = next_y_c;
          state_d     = SCAN_Q;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_random_item_placer.sv
// Self-checking bench for random_item_placer (32x24 main instance, 20x15
// coverage instance). Scan-fallback tests run when
// RANDOM_ITEM_SCAN_FALLBACK_EN is defined.
`timescale 1ns/1ps

module tb_random_item_placer;

  localparam int GW   = 32;
  localparam int GH   = 24;
  localparam int MAXT = 8;
  localparam int SW_W = 20;
  localparam int SW_H = 15;

  typedef struct { int x; int y; } cell_t;
  typedef struct { bit is_fail; int x; int y; int lat; } res_t;

  logic       clk, rst, req, occ_hit;
  logic       busy, occ_valid, item_valid, fail;
  logic [4:0] occ_x, occ_y, item_x, item_y;

  logic       req_s, occ_hit_s;
  logic       busy_s, occ_valid_s, item_valid_s, fail_s;
  logic [4:0] occ_x_s, item_x_s;
  logic [3:0] occ_y_s, item_y_s;

  int tests_run, tests_failed;
  int mode, n_pre, fx, fy;
  int q_idx, q_base;
  int last_x, last_y;
  logic [15:0] m_l;
  cell_t exp_occ[$];
  res_t  exp_res[$];

  random_item_placer dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy),
    .occ_valid(occ_valid), .occ_x(occ_x), .occ_y(occ_y), .occ_hit(occ_hit),
    .item_x(item_x), .item_y(item_y), .item_valid(item_valid), .fail(fail)
  );

  random_item_placer #(.GRID_W(SW_W), .GRID_H(SW_H)) dut_s (
    .clk(clk), .rst(rst), .req(req_s), .busy(busy_s),
    .occ_valid(occ_valid_s), .occ_x(occ_x_s), .occ_y(occ_y_s), .occ_hit(occ_hit_s),
    .item_x(item_x_s), .item_y(item_y_s), .item_valid(item_valid_s), .fail(fail_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic int scale(input logic [7:0] b, input int n);
    return (int'(b) * n) >> 8;
  endfunction

  // Occupancy picture: 0 = first n_pre queries hit, 1 = all hit, 2 = only (fx,fy) free
  function automatic bit hit_fn(input int idx, input int x, input int y);
    if (mode == 0) return idx < n_pre;
    if (mode == 1) return 1'b1;
    return !(x == fx && y == fy);
  endfunction

  // Reference LFSR, free-running like the design's
  always @(posedge clk) m_l <= rst ? 16'hACE1 : step(m_l);

  // Board memory: answers one cycle after each strobe, drives 1 otherwise
  always @(posedge clk) begin
    if (occ_valid) begin
      occ_hit <= hit_fn(q_idx - q_base, int'(occ_x), int'(occ_y));
      q_idx   <= q_idx + 1;
    end else begin
      occ_hit <= 1'b1;
    end
  end

  // Push expected queries and result for a request whose accept edge follows LFSR value l0
  task automatic predict(input logic [15:0] l0);
    logic [15:0] l;
    int cx, cy, lat, idx;
    l = step(l0);
    lat = 0; idx = 0; cx = 0; cy = 0;
    for (int k = 0; k < MAXT; k++) begin
      if (k > 0) l = step(step(step(l)));
      cx = scale(l[15:8], GW);
      cy = scale(l[7:0], GH);
      exp_occ.push_back(cell_t'{cx, cy});
      lat += 3;
      if (!hit_fn(idx, cx, cy)) begin
        exp_res.push_back(res_t'{1'b0, cx, cy, lat});
        last_x = cx; last_y = cy;
        return;
      end
      idx++;
    end
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
    for (int s = 0; s < GW * GH; s++) begin
      if (cx == GW - 1) begin
        cx = 0;
        cy = (cy == GH - 1) ? 0 : cy + 1;
      end else begin
        cx++;
      end
      exp_occ.push_back(cell_t'{cx, cy});
      lat += 2;
      if (!hit_fn(idx, cx, cy)) begin
        exp_res.push_back(res_t'{1'b0, cx, cy, lat});
        last_x = cx; last_y = cy;
        return;
      end
      idx++;
    end
`endif
    exp_res.push_back(res_t'{1'b1, last_x, last_y, lat});
  endtask

  // One request on the main instance, scored against the predicted queue entries
  task automatic run_req(input string name);
    int idx, busy_cnt;
    bit done;
    res_t r;
    cell_t c;
    logic [4:0] ex, ey;
    @(negedge clk);
    predict(m_l);
    q_base = q_idx;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    idx = 0; busy_cnt = 0; done = 1'b0;
    while (!done && idx < 3000) begin
      @(negedge clk);
      if (occ_valid) begin
        tests_run++;
        if (exp_occ.size() == 0) begin
          tests_failed++;
          $display("FAIL %s occ_query: unexpected strobe at (%0d,%0d)", name, occ_x, occ_y);
        end else begin
          c = exp_occ.pop_front();
          ex = 5'(c.x); ey = 5'(c.y);
          if (occ_x !== ex || occ_y !== ey) begin
            tests_failed++;
            $display("FAIL %s occ_query: got (%0d,%0d) want (%0d,%0d)", name, occ_x, occ_y, ex, ey);
          end
        end
      end
      if (item_valid || fail) done = 1'b1;
      else begin
        if (busy) busy_cnt++;
        idx++;
      end
    end
    tests_run++;
    if (!done || exp_res.size() == 0) begin
      tests_failed++;
      $display("FAIL %s completion: done=%0d pending_results=%0d", name, done, exp_res.size());
      exp_occ.delete(); exp_res.delete();
      return;
    end
    r = exp_res.pop_front();
    ex = 5'(r.x); ey = 5'(r.y);
    if (fail !== r.is_fail || item_valid !== !r.is_fail) begin
      tests_failed++;
      $display("FAIL %s outcome: item_valid=%0d fail=%0d want fail=%0d", name, item_valid, fail, r.is_fail);
    end
    tests_run++;
    if (item_x !== ex || item_y !== ey) begin
      tests_failed++;
      $display("FAIL %s item_xy: got (%0d,%0d) want (%0d,%0d)", name, item_x, item_y, ex, ey);
    end
    tests_run++;
    if (idx != r.lat) begin
      tests_failed++;
      $display("FAIL %s latency: got %0d want %0d", name, idx, r.lat);
    end
    tests_run++;
    if (busy_cnt != r.lat || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy: high %0d cycles (busy now %0d) want %0d then 0", name, busy_cnt, busy, r.lat);
    end
    tests_run++;
    if (exp_occ.size() != 0) begin
      tests_failed++;
      $display("FAIL %s occ_count: %0d expected strobes missing", name, exp_occ.size());
    end
    exp_occ.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; req_s = 1'b0; occ_hit_s = 1'b0;
    mode = 0; n_pre = 0; fx = 0; fy = 0; q_base = 0;
    last_x = 0; last_y = 0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({busy, occ_valid, item_valid, fail} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/occ_valid/item_valid/fail=%b want 0000", {busy, occ_valid, item_valid, fail});
    end
    tests_run++;
    if ({occ_x, occ_y, item_x, item_y} !== 20'd0) begin
      tests_failed++;
      $display("FAIL reset_coords: occ=(%0d,%0d) item=(%0d,%0d) want zeros", occ_x, occ_y, item_x, item_y);
    end
    tests_run++;
    if (dut.lfsr !== 16'hACE1) begin
      tests_failed++;
      $display("FAIL reset_lfsr: got %h want ace1", dut.lfsr);
    end
    tests_run++;
    if (busy_s !== 1'b0 || item_valid_s !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_small: busy_s=%0d item_valid_s=%0d want 0", busy_s, item_valid_s);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({busy, occ_valid, item_valid, fail} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL idle_ctrl: busy/occ_valid/item_valid/fail=%b want 0000", {busy, occ_valid, item_valid, fail});
    end
  endtask

  task automatic test_free_cells;
    mode = 0; n_pre = 0;
    run_req("first_free");
    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_req("free_gap");
    end
  endtask

  task automatic test_retry;
    mode = 0;
    n_pre = 3;
    run_req("retry3");
    n_pre = MAXT - 1;
    run_req("retry_last_try");
  endtask

`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
  task automatic test_scan_fallback;
    mode = 2; fx = 5; fy = 7;
    run_req("scan_single_free");
    fx = 31; fy = 23;
    run_req("scan_corner_free");
    fx = 0; fy = 0;
    run_req("scan_origin_free");
    mode = 1;
    run_req("scan_full_board");
  endtask
`else
  task automatic test_exhaust;
    mode = 1;
    run_req("exhaust_all_hit");
    mode = 0; n_pre = 0;
    run_req("after_exhaust");
  endtask
`endif

  // req held high: one placement per IDLE visit, one every 4 cycles
  task automatic test_back_to_back;
    logic [15:0] l;
    int nv, no, nf;
    res_t r;
    logic [4:0] ex, ey;
    mode = 0; n_pre = 0; nv = 0; no = 0; nf = 0;
    @(negedge clk);
    l = step(m_l);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) l = step(step(step(step(l))));
      exp_res.push_back(res_t'{1'b0, scale(l[15:8], GW), scale(l[7:0], GH), 4 * j + 3});
    end
    q_base = q_idx;
    req = 1'b1;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      if (i == 19) req = 1'b0;
      if (occ_valid) no++;
      if (fail) nf++;
      if (item_valid) begin
        nv++;
        tests_run++;
        if (exp_res.size() == 0) begin
          tests_failed++;
          $display("FAIL b2b_extra: unexpected placement at cycle %0d", i);
        end else begin
          r = exp_res.pop_front();
          ex = 5'(r.x); ey = 5'(r.y);
          if (item_x !== ex || item_y !== ey || i != r.lat) begin
            tests_failed++;
            $display("FAIL b2b_item: got (%0d,%0d)@%0d want (%0d,%0d)@%0d", item_x, item_y, i, ex, ey, r.lat);
          end
          last_x = r.x; last_y = r.y;
        end
      end
    end
    tests_run++;
    if (nv != 5 || no != 5 || nf != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_counts: placements=%0d strobes=%0d fails=%0d busy=%0d want 5 5 0 0", nv, no, nf, busy);
    end
    exp_res.delete();
  endtask

  task automatic test_reset_mid;
    mode = 1;
    @(negedge clk);
    predict(m_l);
    q_base = q_idx;
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, occ_valid, item_valid, fail} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_ctrl: busy/occ_valid/item_valid/fail=%b want 0000", {busy, occ_valid, item_valid, fail});
    end
    tests_run++;
    if (dut.lfsr !== 16'hACE1 || item_x !== 5'd0 || item_y !== 5'd0) begin
      tests_failed++;
      $display("FAIL midreset_state: lfsr=%h item=(%0d,%0d) want ace1 (0,0)", dut.lfsr, item_x, item_y);
    end
    rst = 1'b0;
    exp_occ.delete(); exp_res.delete();
    last_x = 0; last_y = 0;
    mode = 0; n_pre = 0;
    run_req("after_midreset");
  endtask

  // 20x15 instance: bounds and full-board coverage over 10000 placements
  task automatic test_coverage;
    bit cov [SW_W][SW_H];
    int placed, bad, nfail, strobes, bad_q, uncovered;
    placed = 0; bad = 0; nfail = 0; strobes = 0; bad_q = 0; uncovered = 0;
    for (int x = 0; x < SW_W; x++)
      for (int y = 0; y < SW_H; y++) cov[x][y] = 1'b0;
    @(negedge clk);
    req_s = 1'b1;
    for (int i = 0; i < 45000 && placed < 10000; i++) begin
      @(negedge clk);
      if (occ_valid_s) begin
        strobes++;
        if (int'(occ_x_s) >= SW_W || int'(occ_y_s) >= SW_H) bad_q++;
      end
      if (fail_s) nfail++;
      if (item_valid_s) begin
        placed++;
        if (int'(item_x_s) >= SW_W || int'(item_y_s) >= SW_H) bad++;
        else cov[int'(item_x_s)][int'(item_y_s)] = 1'b1;
      end
    end
    req_s = 1'b0;
    repeat (6) @(negedge clk);
    for (int x = 0; x < SW_W; x++)
      for (int y = 0; y < SW_H; y++)
        if (!cov[x][y]) uncovered++;
    tests_run++;
    if (placed != 10000 || nfail != 0) begin
      tests_failed++;
      $display("FAIL cov_count: placements=%0d fails=%0d want 10000 0", placed, nfail);
    end
    tests_run++;
    if (bad != 0 || bad_q != 0) begin
      tests_failed++;
      $display("FAIL cov_bounds: %0d items and %0d queries off the 20x15 board, want 0", bad, bad_q);
    end
    tests_run++;
    if (uncovered != 0) begin
      tests_failed++;
      $display("FAIL cov_cells: %0d of 300 cells never placed, want 0", uncovered);
    end
    tests_run++;
    if (strobes - placed < 0 || strobes - placed > 1 || busy_s !== 1'b0) begin
      tests_failed++;
      $display("FAIL cov_strobes: strobes=%0d placements=%0d busy_s=%0d", strobes, placed, busy_s);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_free_cells();
    test_retry();
`ifdef RANDOM_ITEM_SCAN_FALLBACK_EN
    test_scan_fallback();
`else
    test_exhaust();
`endif
    test_back_to_back();
    test_reset_mid();
    test_coverage();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
